// File: rtl/mul_pkg.sv
// Shared FSM state encoding and default widths for the multiply-accumulate slice.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_LEN_W = 9;

endpackage

// File: rtl/mul_accumulator_beat_counter.sv
// Beat counter: holds the latched transaction length and flags the last beat.
module beat_counter
  import mul_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [LEN_W-1:0] len_in,
  input  logic             en,
  output logic             tc
);

  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_nxt;

  assign cnt_nxt = count + 1'b1;

  // Terminal count: the beat being accepted now is number len.
  assign tc = en && (cnt_nxt == len_q);

  // Clear and load the length on start; advance on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      len_q <= '0;
    end else if (clr) begin
      count <= '0;
      len_q <= len_in;
    end else if (en) begin
      count <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates len unsigned products from an external multiplier; result held
// until the consumer takes it. Sum wraps, carry-out sets a sticky ovf.
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int PROD_W = 2*WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  if (ACC_W < PROD_W) begin : g_acc_w_chk
    $error("mul_accumulator: ACC_W must be >= 2*WIDTH");
  end

  state_e         state, state_nxt;
  logic           take_start;
  logic           beat;
  logic           last_beat;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc;
  logic           ovf_q;

  assign take_start = (state == IDLE) && start;
  assign beat       = (state == ACC) && in_valid;
  assign sum        = {1'b0, acc} + (ACC_W+1)'(prod);

  beat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (take_start),
    .len_in (len),
    .en     (beat),
    .tc     (last_beat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)     state_nxt = (len == '0) ? DONE : ACC;
      ACC:  if (last_beat) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Accumulator and sticky overflow; cleared on start, updated per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (take_start) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (beat) begin
      acc   <= sum[ACC_W-1:0];
      ovf_q <= ovf_q | sum[ACC_W];
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench: expected results go into a scoreboard queue; a monitor pops
// and compares on every result handshake.
module tb_mul_accumulator;

  localparam int WIDTH  = 4;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 9;
  localparam int PROD_W = 2*WIDTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;
  logic              busy;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  mul_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got acc 0x%0h with no expected entry", acc_out);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("result_acc", 32'(acc_out), 32'(e.acc));
        chk("result_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    cyc();
    start = 1'b0;
  endtask

  // Present one product and hold it until it is accepted (bounded).
  task automatic beat(input int p);
    int k;
    in_valid = 1'b1;
    prod     = PROD_W'(p);
    k = 0;
    while (!in_ready && k < 20) begin
      cyc();
      k++;
    end
    if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      cyc();
      k++;
    end
    if (sb.size() != 0) chk("result_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    prod = '0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // len=3, 225 x3 = 675 = 0x2A3
    sb.push_back('{acc: 16'h02A3, ovf: 1'b0});
    do_start(3);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    beat(225);
    beat(225);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    beat(225);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_in_ready_done", 32'(in_ready), 32'd0);
    wait_done();

    // len=0: result of zero on the next cycle, in_ready stays low
    sb.push_back('{acc: 16'h0000, ovf: 1'b0});
    start = 1'b1; len = '0;
    chk("t2_in_ready_idle", 32'(in_ready), 32'd0);
    cyc();
    start = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_in_ready_done", 32'(in_ready), 32'd0);
    wait_done();
    chk("t2_idle", 32'(busy), 32'd0);

    // len=292 of 225: 65700 mod 65536 = 164, carry seen
    sb.push_back('{acc: 16'd164, ovf: 1'b1});
    do_start(292);
    for (int i = 0; i < 292; i++) beat(225);
    wait_done();

    // len=2 with a 4-cycle gap; consumer stalls 5 cycles
    sb.push_back('{acc: 16'd30, ovf: 1'b0});
    out_ready = 1'b0;
    do_start(2);
    beat(10);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_gap_acc", 32'(acc_out), 32'd10);
    end
    chk("t4_gap_in_ready", 32'(in_ready), 32'd1);
    beat(20);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_acc", 32'(acc_out), 32'd30);
      cyc();
    end
    out_ready = 1'b1;
    wait_done();

    // Reset mid-ACC after 2 of 4 beats: abandoned, no result expected
    do_start(4);
    beat(5);
    beat(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_acc", 32'(acc_out), 32'd0);
    chk("t5_rst_ovf", 32'(ovf), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    sb.push_back('{acc: 16'd7, ovf: 1'b0});
    do_start(1);
    beat(7);
    wait_done();

    // start ignored in ACC and DONE, including the cycle DONE is left
    sb.push_back('{acc: 16'd175, ovf: 1'b0});
    do_start(3);
    beat(100);
    start = 1'b1; len = '0;
    beat(50);
    chk("t6_acc_mid", 32'(acc_out), 32'd150);
    chk("t6_still_acc", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    beat(25);
    cyc();
    chk("t6_done_valid", 32'(out_valid), 32'd1);
    chk("t6_done_acc", 32'(acc_out), 32'd175);
    out_ready = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_left_done_busy", 32'(busy), 32'd0);
    chk("t6_left_done_valid", 32'(out_valid), 32'd0);
    wait_done();

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_accumulator.md
MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Interface
REQ-001 Parameter WIDTH, default 4: multiplier operand width; the product width is PROD_W = 2*WIDTH.
REQ-002 Parameter ACC_W, default 16: accumulator width; the block SHALL require ACC_W >= PROD_W.
REQ-003 Parameter LEN_W, default 9: width of the transaction length field.
REQ-004 Single clock domain; reset asynchronous, active-low; no other clock or reset SHALL exist.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a transaction; sampled only in IDLE.
REQ-008 len  input  LEN_W  number of products to accumulate; sampled with start.
REQ-009 in_valid  input  1  prod is valid this cycle.
REQ-010 in_ready  output  1  block accepts prod this cycle.
REQ-011 prod  input  PROD_W  unsigned product from the combinational multiplier output.
REQ-012 out_valid  output  1  acc_out and ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 acc_out  output  ACC_W  accumulated sum, modulo 2^ACC_W.
REQ-015 ovf  output  1  sticky flag; set when any addition carries out of ACC_W bits.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-018 IDLE, start=1, len!=0: clear the accumulator, count and ovf; latch len; next state ACC.
REQ-019 IDLE, start=1, len=0: clear the accumulator and ovf; next state DONE, so out_valid=1 and acc_out=0 one cycle later.
REQ-020 ACC: in_ready=1; a beat is accepted when in_valid && in_ready, which SHALL perform acc += prod and count += 1.
REQ-021 ACC: a cycle with in_valid=0 SHALL leave the accumulator, count and state unchanged.
REQ-022 ACC: acceptance of beat number len SHALL move the FSM to DONE, so out_valid rises the cycle after the last accepted beat (latency 1).
REQ-023 in_ready SHALL be 0 in IDLE and DONE; prod outside ACC is ignored.
REQ-024 DONE: out_valid=1; acc_out and ovf SHALL hold stable until out_valid && out_ready, then the next state is IDLE.
REQ-025 start SHALL be ignored outside IDLE, including in the cycle that DONE is left.
REQ-026 Addition is unsigned: the sum wraps modulo 2^ACC_W, and the carry-out sets ovf, which stays set until the next accepted start.
REQ-027 acc_out and ovf SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-028 Assertion of rst_n=0 SHALL immediately force state=IDLE, accumulator=0, count=0, latched len=0 and ovf=0, regardless of clk.
REQ-029 While rst_n=0, the outputs SHALL be in_ready=0, out_valid=0, busy=0, acc_out=0 and ovf=0.
REQ-030 Reset during ACC or DONE SHALL abandon the transaction without emitting a result.

Structure
REQ-031 A shared package mul_pkg SHALL hold the state enum (IDLE, ACC, DONE) and the default width constants.
REQ-032 One sub-module is natural: beat_counter (LEN_W-bit, with clear, enable and terminal-count output compared against the latched len).
REQ-033 The multiplier SHALL NOT be instantiated inside this block; prod is connected externally from the multiplier's out.

Verification
REQ-034 len=3, prod=225,225,225 with in_valid held high -> out_valid one cycle after the 3rd beat, acc_out=0x02A3, ovf=0.
REQ-035 len=0 with start=1 -> the next cycle gives out_valid=1, acc_out=0, in_ready never asserted.
REQ-036 len=292, prod=225 on every beat -> acc_out=164 (65700 mod 65536), ovf=1.
REQ-037 len=2 with in_valid low for 4 cycles between the two beats (10, 20) -> acc_out=30; out_ready held low for 5 cycles -> acc_out stable and out_valid held throughout.
REQ-038 rst_n pulsed low mid-ACC after 2 of 4 beats -> outputs are zero asynchronously; a new start with len=1 and prod=7 -> acc_out=7, ovf=0.
REQ-039 start asserted during ACC and during DONE -> ignored; the running sum is unaffected.
